uart_packet_parser: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the echo/ALU datapath.
- Consumes the RX byte stream and decodes packets: opcode, reserved byte, 16-bit little-endian total length, then payload.
- Passes echo payload through byte-by-byte.
- Packs ALU payload into 32-bit big-endian operands.
- Flags malformed packets and stalled packets, then resynchronises.

---
 rtl/uart_packet_parser_if.sv | 31 +++
 rtl/uart_packet_parser.sv | 185 ++++++++++++++++++
 tb/tb_uart_packet_parser.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_parser_if.sv
// Handshake bundle between the UART receiver, the packet parser and the echo/ALU consumers.
interface uart_packet_parser_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        hdr_valid_o;
  logic [7:0]  opcode_o;
  logic [15:0] length_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_last_o;
  logic        operand_ready_i;
  logic        err_o;

  // Parser side
  modport slave (
    input  rx_data_i, rx_valid_i, echo_ready_i, operand_ready_i,
    output rx_ready_o, hdr_valid_o, opcode_o, length_o, echo_data_o, echo_valid_o,
           operand_o, operand_valid_o, operand_last_o, err_o
  );

  // Receiver/consumer side
  modport master (
    output rx_data_i, rx_valid_i, echo_ready_i, operand_ready_i,
    input  rx_ready_o, hdr_valid_o, opcode_o, length_o, echo_data_o, echo_valid_o,
           operand_o, operand_valid_o, operand_last_o, err_o
  );
endinterface

// File: rtl/uart_packet_parser.sv
// UART packet parser: decodes opcode/reserved/length header, forwards echo payload
// bytes, packs ALU payload into big-endian 32-bit operands, flags bad or stalled packets.
module uart_packet_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  OP_ECHO        = 8'hEC,
  parameter logic [7:0]  OP_ADD         = 8'hAD,
  parameter logic [7:0]  OP_MUL         = 8'h88,
  parameter logic [7:0]  OP_DIV         = 8'h8A
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  uart_packet_parser_if.slave bus
);

  localparam logic [2:0] S_OPCODE  = 3'd0;
  localparam logic [2:0] S_RSVD    = 3'd1;
  localparam logic [2:0] S_LEN_LSB = 3'd2;
  localparam logic [2:0] S_LEN_MSB = 3'd3;
  localparam logic [2:0] S_ECHO    = 3'd4;
  localparam logic [2:0] S_OPER    = 3'd5;
  localparam logic [2:0] S_DROP    = 3'd6;

  logic [2:0]  r_state;
  logic [7:0]  r_op_hold;
  logic [7:0]  r_len_lsb;
  logic [7:0]  r_opcode;
  logic [15:0] r_length;
  logic [15:0] r_count;
  logic        r_hdr_valid;
  logic        r_err;
  logic [7:0]  r_echo_data;
  logic        r_echo_valid;
  logic [23:0] r_shift;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_operand;
  logic        r_operand_valid;
  logic        r_operand_last;
  logic [31:0] r_timer;

  logic        w_ready;
  logic        w_accept;
  logic        w_last;
  logic        w_is_alu;
  logic        w_timeout;
  logic [15:0] w_len;
  logic [15:0] w_pay;

  // Byte acceptance, header length decode and timeout detection
  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      S_ECHO:  w_ready = !r_echo_valid || bus.echo_ready_i;
      S_OPER:  w_ready = !r_operand_valid || bus.operand_ready_i;
      default: w_ready = 1'b1;
    endcase
    w_accept  = bus.rx_valid_i && w_ready;
    w_len     = {bus.rx_data_i, r_len_lsb};
    w_pay     = w_len - 16'd4;
    w_last    = (r_count == 16'd1);
    w_is_alu  = (r_op_hold == OP_ADD) || (r_op_hold == OP_MUL) || (r_op_hold == OP_DIV);
    // An accepted byte needs rx_valid_i high, so it always beats expiry.
    w_timeout = (r_state != S_OPCODE) && !bus.rx_valid_i
                && ((r_timer + 32'd1) == 32'(TIMEOUT_CYCLES));
  end

  // Packet FSM, header latching, payload down-counter and error/header pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_OPCODE;
      r_op_hold   <= '0;
      r_len_lsb   <= '0;
      r_opcode    <= '0;
      r_length    <= '0;
      r_count     <= '0;
      r_hdr_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_OPCODE: begin
            r_op_hold <= bus.rx_data_i;
            r_state   <= S_RSVD;
          end
          S_RSVD:    r_state <= S_LEN_LSB;
          S_LEN_LSB: begin
            r_len_lsb <= bus.rx_data_i;
            r_state   <= S_LEN_MSB;
          end
          S_LEN_MSB: begin
            r_opcode    <= r_op_hold;
            r_length    <= w_len;
            r_hdr_valid <= 1'b1;
            if (w_len < 16'd4) begin
              r_err   <= 1'b1;
              r_state <= S_OPCODE;
            end else begin
              r_count <= w_pay;
              if (w_len == 16'd4)
                r_state <= S_OPCODE;
              else if (r_op_hold == OP_ECHO)
                r_state <= S_ECHO;
              else if (w_is_alu && (w_pay[1:0] == 2'b00))
                r_state <= S_OPER;
              else begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end
            end
          end
          S_ECHO, S_OPER, S_DROP: begin
            r_count <= r_count - 16'd1;
            if (w_last) r_state <= S_OPCODE;
          end
          default: r_state <= S_OPCODE;
        endcase
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= S_OPCODE;
      end
    end
  end

  // Echo output register: one byte of latency, holds while the consumer stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_echo_data  <= '0;
      r_echo_valid <= 1'b0;
    end else if (w_accept && (r_state == S_ECHO)) begin
      r_echo_data  <= bus.rx_data_i;
      r_echo_valid <= 1'b1;
    end else if (bus.echo_ready_i) begin
      r_echo_valid <= 1'b0;
    end
  end

  // Operand assembly: MSB-first shift, publish on every fourth byte
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift         <= '0;
      r_byte_idx      <= '0;
      r_operand       <= '0;
      r_operand_valid <= 1'b0;
      r_operand_last  <= 1'b0;
    end else begin
      if (r_operand_valid && bus.operand_ready_i) r_operand_valid <= 1'b0;
      if (w_accept && (r_state == S_OPER)) begin
        r_shift    <= {r_shift[15:0], bus.rx_data_i};
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_operand       <= {r_shift, bus.rx_data_i};
          r_operand_valid <= 1'b1;
          r_operand_last  <= w_last;
        end
      end else if (w_timeout) begin
        // Drop the partial group only; an already published operand still drains.
        r_shift    <= '0;
        r_byte_idx <= '0;
      end
    end
  end

  // Inter-byte idle timer, active only while a packet is in progress
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_timer <= '0;
    else if (w_accept || w_timeout || (r_state == S_OPCODE))
      r_timer <= '0;
    else if (!bus.rx_valid_i)
      r_timer <= r_timer + 32'd1;
  end

  assign bus.rx_ready_o      = rst_ni && w_ready;
  assign bus.hdr_valid_o     = r_hdr_valid;
  assign bus.opcode_o        = r_opcode;
  assign bus.length_o        = r_length;
  assign bus.echo_data_o     = r_echo_data;
  assign bus.echo_valid_o    = r_echo_valid;
  assign bus.operand_o       = r_operand;
  assign bus.operand_valid_o = r_operand_valid;
  assign bus.operand_last_o  = r_operand_last;
  assign bus.err_o           = r_err;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Testbench for uart_packet_parser: directed packets plus randomized packets,
// checked against a packet-level reference model and output scoreboards.
module tb_uart_packet_parser;

  localparam int unsigned TO = 64;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  uart_packet_parser_if bus ();

  uart_packet_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Scoreboards filled by the reference model
  logic [23:0] exp_hdr[$];
  logic [7:0]  exp_echo[$];
  logic [32:0] exp_oper[$];
  int          exp_err;
  int          obs_err;
  int          echo_cyc[$];

  // Consumer-ready control
  logic rand_rdy;
  logic echo_rdy_force;
  logic op_rdy_force;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer ready driver
  initial begin
    bus.echo_ready_i    = 1'b1;
    bus.operand_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (rand_rdy) begin
        bus.echo_ready_i    = ($urandom_range(0, 99) < 70);
        bus.operand_ready_i = ($urandom_range(0, 99) < 70);
      end else begin
        bus.echo_ready_i    = echo_rdy_force;
        bus.operand_ready_i = op_rdy_force;
      end
    end
  end

  // Output monitor: header pulses, transfers, hold-under-backpressure
  logic        echo_hold, oper_hold;
  logic [7:0]  held_echo;
  logic [32:0] held_oper;
  initial begin
    echo_hold = 1'b0;
    oper_hold = 1'b0;
    held_echo = '0;
    held_oper = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        echo_hold = 1'b0;
        oper_hold = 1'b0;
      end else begin
        if (echo_hold) begin
          check("echo_hold_valid", bus.echo_valid_o, 1);
          check("echo_hold_data", bus.echo_data_o, held_echo);
        end
        if (oper_hold) begin
          check("oper_hold_valid", bus.operand_valid_o, 1);
          check("oper_hold_data", {bus.operand_last_o, bus.operand_o}, held_oper);
        end
        if (bus.hdr_valid_o) begin
          if (exp_hdr.size() == 0) check("hdr_extra", bus.hdr_valid_o, 0);
          else check("hdr", {bus.opcode_o, bus.length_o}, exp_hdr.pop_front());
        end
        if (bus.err_o) obs_err++;
        if (bus.echo_valid_o && bus.echo_ready_i) begin
          echo_cyc.push_back(cyc);
          if (exp_echo.size() == 0) check("echo_extra", bus.echo_valid_o, 0);
          else check("echo_data", bus.echo_data_o, exp_echo.pop_front());
        end
        if (bus.operand_valid_o && bus.operand_ready_i) begin
          if (exp_oper.size() == 0) check("oper_extra", bus.operand_valid_o, 0);
          else check("operand", {bus.operand_last_o, bus.operand_o}, exp_oper.pop_front());
        end
        echo_hold = bus.echo_valid_o && !bus.echo_ready_i;
        held_echo = bus.echo_data_o;
        oper_hold = bus.operand_valid_o && !bus.operand_ready_i;
        held_oper = {bus.operand_last_o, bus.operand_o};
      end
    end
  end

  // Reference model: expected outputs of one complete packet
  task automatic model(input bq_t p);
    logic [15:0] len;
    int unsigned pay;
    len = {p[3], p[2]};
    exp_hdr.push_back({p[0], len});
    if (len < 16'd4) begin
      exp_err++;
      return;
    end
    pay = {16'd0, len} - 32'd4;
    if (pay == 0) return;
    if (p[0] == 8'hEC) begin
      for (int unsigned i = 0; i < pay; i++) exp_echo.push_back(p[4 + i]);
    end else if ((p[0] inside {8'hAD, 8'h88, 8'h8A}) && (pay % 4 == 0)) begin
      for (int unsigned g = 0; g < pay / 4; g++)
        exp_oper.push_back({(g == pay / 4 - 1), p[4 + 4*g], p[5 + 4*g], p[6 + 4*g], p[7 + 4*g]});
    end else begin
      exp_err++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic        acc;
    int unsigned n;
    n = 0;
    @(negedge clk);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    forever begin
      #1;
      acc = bus.rx_ready_o;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 400) begin
        check("send_stall", bus.rx_ready_o, 1);
        break;
      end
      @(negedge clk);
    end
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_raw(input bq_t p, input int unsigned gapmax);
    foreach (p[i]) begin
      send_byte(p[i]);
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
  endtask

  task automatic send_pkt(input bq_t p, input int unsigned gapmax);
    model(p);
    send_raw(p, gapmax);
  endtask

  task automatic rand_pkt();
    bq_t         p;
    logic [7:0]  op;
    logic [15:0] len;
    logic [7:0]  alu_ops[3];
    alu_ops = '{8'hAD, 8'h88, 8'h8A};
    case ($urandom_range(0, 4))
      0: begin op = 8'hEC; len = 16'(4 + $urandom_range(0, 12)); end
      1: begin op = alu_ops[$urandom_range(0, 2)]; len = 16'(4 + 4 * $urandom_range(0, 4)); end
      2: begin
        op  = alu_ops[$urandom_range(0, 2)];
        len = 16'(4 + 4 * $urandom_range(0, 3) + $urandom_range(1, 3));
      end
      3: begin
        do op = 8'($urandom); while (op inside {8'hEC, 8'hAD, 8'h88, 8'h8A});
        len = 16'(5 + $urandom_range(0, 10));
      end
      default: begin op = 8'($urandom); len = 16'($urandom_range(0, 3)); end
    endcase
    p = '{op, 8'($urandom), len[7:0], len[15:8]};
    if (len >= 16'd4)
      for (int unsigned i = 0; i < 32'(len) - 4; i++) p.push_back(8'($urandom));
    send_pkt(p, 2);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  bq_t         pkt;
  int unsigned w;
  int unsigned first_err;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err = 0;
    obs_err = 0;
    rand_rdy = 1'b0;
    echo_rdy_force = 1'b1;
    op_rdy_force = 1'b1;
    rst_n = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = '0;

    // Reset state
    #3;
    check("rst_rx_ready", bus.rx_ready_o, 0);
    check("rst_hdr_valid", bus.hdr_valid_o, 0);
    check("rst_err", bus.err_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rx_ready", bus.rx_ready_o, 1);
    check("post_rst_opcode", bus.opcode_o, 0);
    check("post_rst_length", bus.length_o, 0);
    check("post_rst_operand", bus.operand_o, 0);
    check("post_rst_echo_data", bus.echo_data_o, 0);
    check("post_rst_valids", {bus.echo_valid_o, bus.operand_valid_o, bus.operand_last_o}, 0);

    // Echo at full throughput
    echo_cyc.delete();
    pkt = '{8'hEC, 8'hF4, 8'h0C, 8'h00, 8'h48, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(pkt, 0);
    wait_cycles(4);
    check("echo_count", echo_cyc.size(), 8);
    if (echo_cyc.size() == 8) check("echo_throughput", echo_cyc[7] - echo_cyc[0], 7);
    check("echo_back_to_opcode", bus.rx_ready_o, 1);
    check("echo_left", exp_echo.size(), 0);

    // Add packet
    pkt = '{8'hAD, 8'hF4, 8'h0C, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1A, 8'h98, 8'h31, 8'hAB};
    send_pkt(pkt, 1);
    wait_cycles(4);
    check("add_oper_left", exp_oper.size(), 0);
    check("add_no_err", obs_err, exp_err);

    // Add packet with operand consumer stalled after the first operand
    op_rdy_force = 1'b0;
    fork
      send_pkt(pkt, 0);
      begin
        w = 0;
        while (!bus.operand_valid_o && w < 200) begin
          @(negedge clk);
          #2;
          w++;
        end
        check("bp_first_valid", bus.operand_valid_o, 1);
        repeat (20) begin
          @(negedge clk);
          #2;
        end
        check("bp_held_operand", bus.operand_o, 32'hDEADBEEF);
        check("bp_rx_ready_low", bus.rx_ready_o, 0);
        op_rdy_force = 1'b1;
      end
    join
    wait_cycles(4);
    check("bp_oper_left", exp_oper.size(), 0);

    // Malformed packets then a good echo packet
    pkt = '{8'hAD, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(pkt, 0);
    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h77, 8'h88};
    send_pkt(pkt, 0);
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'hA1, 8'hB2, 8'hC3};
    send_pkt(pkt, 0);
    wait_cycles(4);
    check("malformed_err_count", obs_err, exp_err);
    check("malformed_echo_left", exp_echo.size(), 0);

    // Timeout mid-packet
    exp_hdr.push_back({8'hEC, 16'h000C});
    exp_echo.push_back(8'h48);
    exp_err++;
    pkt = '{8'hEC, 8'hF4, 8'h0C, 8'h00, 8'h48};
    send_raw(pkt, 0);
    first_err = 0;
    for (int unsigned k = 1; k <= TO + 5; k++) begin
      @(posedge clk);
      #1;
      if (bus.err_o && first_err == 0) first_err = k;
    end
    check("timeout_cycle", first_err, TO);
    check("timeout_to_opcode", bus.rx_ready_o, 1);
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
    send_pkt(pkt, 0);
    wait_cycles(4);
    check("timeout_err_count", obs_err, exp_err);
    check("timeout_echo_left", exp_echo.size(), 0);

    // Asynchronous reset mid-packet
    exp_hdr.push_back({8'hAD, 16'h000C});
    pkt = '{8'hAD, 8'hF4, 8'h0C, 8'h00, 8'hDE};
    send_raw(pkt, 0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("amid_rst_rx_ready", bus.rx_ready_o, 0);
    check("amid_rst_opcode", bus.opcode_o, 0);
    check("amid_rst_length", bus.length_o, 0);
    check("amid_rst_echo_data", bus.echo_data_o, 0);
    check("amid_rst_pulses", {bus.hdr_valid_o, bus.err_o, bus.echo_valid_o, bus.operand_valid_o}, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(pkt, 0);
    wait_cycles(4);
    check("post_reset_echo_left", exp_echo.size(), 0);
    check("post_reset_err_count", obs_err, exp_err);

    // Randomized packets with random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) rand_pkt();
    rand_rdy = 1'b0;
    echo_rdy_force = 1'b1;
    op_rdy_force = 1'b1;
    wait_cycles(20);
    check("final_hdr_left", exp_hdr.size(), 0);
    check("final_echo_left", exp_echo.size(), 0);
    check("final_oper_left", exp_oper.size(), 0);
    check("final_err_count", obs_err, exp_err);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
